spi_bus_arbiter: RTL and testbench

//  Shares the single internal peripheral bus (BRAM, UART, mic array, etc.) between two
//  SPI-slave front ends: the RPi host and the ESP32. One transaction is in flight at a time.

---
 rtl/creator_bus_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 42 ++++
 rtl/spi_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/creator_bus_pkg.sv
`default_nettype none
// ============================================================================
// creator_bus_pkg : shared encodings for the SPI-front-end bus arbiter
// Revision 1.0
// ============================================================================
package creator_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_RPI = 1'b0,
    REQ_ESP = 1'b1
  } req_id_t;

  localparam logic [15:0] ERR_RDATA = 16'h0000;

  // One-hot grant vector is {esp, rpi}.
  function automatic logic [1:0] grant_of(input req_id_t id);
    return (id == REQ_ESP) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// bus_watchdog : bounds a bus access; expired_o fires on the TIMEOUT-th cycle
// Revision 1.0
// ============================================================================
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the cycle whose closing edge brings the count to TIMEOUT.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// spi_bus_arbiter : shares the peripheral bus between RPi and ESP32 SPI slaves
// Revision 1.0
// ============================================================================
module spi_bus_arbiter
  import creator_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 16,
  parameter int TIMEOUT      = 255,
  parameter bit RPI_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn_i,
  input  logic                  rpi_req_i,
  input  logic                  rpi_lock_i,
  input  logic                  rpi_we_i,
  input  logic [ADDR_WIDTH-1:0] rpi_addr_i,
  input  logic [DATA_WIDTH-1:0] rpi_wdata_i,
  output logic                  rpi_ack_o,
  output logic                  rpi_err_o,
  output logic [DATA_WIDTH-1:0] rpi_rdata_o,
  input  logic                  esp_req_i,
  input  logic                  esp_lock_i,
  input  logic                  esp_we_i,
  input  logic [ADDR_WIDTH-1:0] esp_addr_i,
  input  logic [DATA_WIDTH-1:0] esp_wdata_i,
  output logic                  esp_ack_o,
  output logic                  esp_err_o,
  output logic [DATA_WIDTH-1:0] esp_rdata_o,
  output logic                  bus_stb_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic [1:0]            grant_o
);

  state_t                state_q;
  req_id_t               owner_q;
  req_id_t               last_grant_q;
  logic                  bus_stb_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [1:0]            grant_q;
  logic                  rpi_ack_q;
  logic                  rpi_err_q;
  logic [DATA_WIDTH-1:0] rpi_rdata_q;
  logic                  esp_ack_q;
  logic                  esp_err_q;
  logic [DATA_WIDTH-1:0] esp_rdata_q;

  logic                  w_expired;
  logic                  w_esp_wins;
  req_id_t               w_pick;
  req_id_t               w_src;
  logic                  w_src_we;
  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic [DATA_WIDTH-1:0] w_src_wdata;
  logic                  w_own_req;
  logic                  w_own_lock;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_i     (resetn_i),
    .clr_i     (state_q == ST_RESP),
    .en_i      (state_q == ST_ACTIVE),
    .expired_o (w_expired)
  );

  // ESP wins only when alone, or on a tie when the RPi was served last.
  assign w_esp_wins = esp_req_i &&
                      (!rpi_req_i || (!RPI_PRIORITY && (last_grant_q == REQ_RPI)));
  assign w_pick     = w_esp_wins ? REQ_ESP : REQ_RPI;

  assign w_src       = (state_q == ST_IDLE) ? w_pick : owner_q;
  assign w_src_we    = (w_src == REQ_ESP) ? esp_we_i    : rpi_we_i;
  assign w_src_addr  = (w_src == REQ_ESP) ? esp_addr_i  : rpi_addr_i;
  assign w_src_wdata = (w_src == REQ_ESP) ? esp_wdata_i : rpi_wdata_i;

  assign w_own_req  = (owner_q == REQ_ESP) ? esp_req_i  : rpi_req_i;
  assign w_own_lock = (owner_q == REQ_ESP) ? esp_lock_i : rpi_lock_i;

  assign w_rsp_err   = !bus_ack_i;
  assign w_rsp_rdata = bus_ack_i ? bus_rdata_i : DATA_WIDTH'(ERR_RDATA);

  always_ff @(posedge clk) begin
    if (resetn_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_RPI;
      last_grant_q <= REQ_ESP;
      bus_stb_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      grant_q      <= 2'b00;
      rpi_ack_q    <= 1'b0;
      rpi_err_q    <= 1'b0;
      rpi_rdata_q  <= '0;
      esp_ack_q    <= 1'b0;
      esp_err_q    <= 1'b0;
      esp_rdata_q  <= '0;
    end else begin
      rpi_ack_q   <= 1'b0;
      rpi_err_q   <= 1'b0;
      rpi_rdata_q <= '0;
      esp_ack_q   <= 1'b0;
      esp_err_q   <= 1'b0;
      esp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (rpi_req_i || esp_req_i) begin
            owner_q     <= w_pick;
            grant_q     <= grant_of(w_pick);
            bus_we_q    <= w_src_we;
            bus_addr_q  <= w_src_addr;
            bus_wdata_q <= w_src_wdata;
            bus_stb_q   <= 1'b1;
            state_q     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A slave ack in the expiry cycle still counts as a good completion.
          if (bus_ack_i || w_expired) begin
            bus_stb_q <= 1'b0;
            state_q   <= ST_RESP;
            if (owner_q == REQ_ESP) begin
              esp_ack_q   <= 1'b1;
              esp_err_q   <= w_rsp_err;
              esp_rdata_q <= w_rsp_rdata;
            end else begin
              rpi_ack_q   <= 1'b1;
              rpi_err_q   <= w_rsp_err;
              rpi_rdata_q <= w_rsp_rdata;
            end
          end
        end
        ST_RESP: begin
          if (w_own_lock) begin
            state_q <= ST_HOLD;
          end else begin
            state_q      <= ST_IDLE;
            last_grant_q <= owner_q;
            grant_q      <= 2'b00;
          end
        end
        ST_HOLD: begin
          if (w_own_req) begin
            bus_we_q    <= w_src_we;
            bus_addr_q  <= w_src_addr;
            bus_wdata_q <= w_src_wdata;
            bus_stb_q   <= 1'b1;
            state_q     <= ST_ACTIVE;
          end else if (!w_own_lock) begin
            state_q      <= ST_IDLE;
            last_grant_q <= owner_q;
            grant_q      <= 2'b00;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_stb_o   = bus_stb_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign grant_o     = grant_q;
  assign rpi_ack_o   = rpi_ack_q;
  assign rpi_err_o   = rpi_err_q;
  assign rpi_rdata_o = rpi_rdata_q;
  assign esp_ack_o   = esp_ack_q;
  assign esp_err_o   = esp_err_q;
  assign esp_rdata_o = esp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_bus_arbiter : scoreboard bench for spi_bus_arbiter
// Revision 1.0
// ============================================================================
module tb_spi_bus_arbiter;

  localparam bit RPI_PRIORITY = 1'b0;

  typedef struct {
    int          who;
    logic        err;
    logic [15:0] rdata;
  } resp_t;

  typedef struct {
    int          who;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        rpi_req = 1'b0, rpi_lock = 1'b0, rpi_we = 1'b0;
  logic [14:0] rpi_addr = '0;
  logic [15:0] rpi_wdata = '0;
  logic        esp_req = 1'b0, esp_lock = 1'b0, esp_we = 1'b0;
  logic [14:0] esp_addr = '0;
  logic [15:0] esp_wdata = '0;
  logic        rpi_ack, rpi_err, esp_ack, esp_err;
  logic [15:0] rpi_rdata, esp_rdata;
  logic        bus_stb, bus_we;
  logic [14:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] slv_mem[int];
  int          last_served = 1;
  int          slave_wait = 0;
  bit          slave_mute = 1'b0;

  spi_bus_arbiter #(
    .ADDR_WIDTH   (15),
    .DATA_WIDTH   (16),
    .TIMEOUT      (255),
    .RPI_PRIORITY (RPI_PRIORITY)
  ) dut (
    .clk         (clk),
    .resetn_i    (resetn),
    .rpi_req_i   (rpi_req),
    .rpi_lock_i  (rpi_lock),
    .rpi_we_i    (rpi_we),
    .rpi_addr_i  (rpi_addr),
    .rpi_wdata_i (rpi_wdata),
    .rpi_ack_o   (rpi_ack),
    .rpi_err_o   (rpi_err),
    .rpi_rdata_o (rpi_rdata),
    .esp_req_i   (esp_req),
    .esp_lock_i  (esp_lock),
    .esp_we_i    (esp_we),
    .esp_addr_i  (esp_addr),
    .esp_wdata_i (esp_wdata),
    .esp_ack_o   (esp_ack),
    .esp_err_o   (esp_err),
    .esp_rdata_o (esp_rdata),
    .bus_stb_o   (bus_stb),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_rdata_i (bus_rdata),
    .bus_ack_i   (bus_ack),
    .grant_o     (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [14:0] a);
    return {1'b1, a} ^ 16'h5A5A;
  endfunction

  // Reference model: one access at a time, served in arbitration order.
  function automatic int ref_pick(input bit r, input bit e);
    if (r && e) return (RPI_PRIORITY || last_served == 1) ? 0 : 1;
    return r ? 0 : 1;
  endfunction

  function automatic void ref_serve(input int who, input logic we,
                                    input logic [14:0] a, input logic [15:0] d);
    resp_t r;
    bus_t  b;
    b.who = who; b.we = we; b.addr = a; b.wdata = d;
    bus_q.push_back(b);
    r.who = who;
    r.err = 1'b0;
    if (we) begin
      ref_mem[int'(a)] = d;
      r.rdata = d;
    end else begin
      r.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    end
    resp_q.push_back(r);
    last_served = who;
  endfunction

  task automatic drive(input int who, input logic req, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
    if (who == 0) begin
      rpi_req = req; rpi_we = we; rpi_addr = a; rpi_wdata = d;
    end else begin
      esp_req = req; esp_we = we; esp_addr = a; esp_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int who);
    return (who == 0) ? rpi_ack : esp_ack;
  endfunction

  // Raise req, hold it until our ack shows, then drop it; lat = cycles to ack.
  task automatic access(input int who, input logic we, input logic [14:0] a,
                        input logic [15:0] d, output int lat);
    lat = 0;
    drive(who, 1'b1, we, a, d);
    while (!ack_of(who) && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 1000) chk("access_ack_timeout", 32'(lat), 32'd0);
    drive(who, 1'b0, we, a, d);
  endtask

  task automatic round(input bit r, input bit e);
    logic [14:0] ar, ae;
    logic [15:0] dr, de;
    logic        wr, we_;
    int          lr, le;
    ar  = 15'h2000 + 15'($urandom_range(0, 7));
    ae  = 15'h2000 + 15'($urandom_range(0, 7));
    dr  = 16'($urandom);
    de  = 16'($urandom);
    wr  = 1'($urandom_range(0, 1));
    we_ = 1'($urandom_range(0, 1));
    if (ref_pick(r, e) == 0) begin
      ref_serve(0, wr, ar, dr);
      if (e) ref_serve(1, we_, ae, de);
    end else begin
      ref_serve(1, we_, ae, de);
      if (r) ref_serve(0, wr, ar, dr);
    end
    fork
      begin if (r) access(0, wr, ar, dr, lr); end
      begin if (e) access(1, we_, ae, de, le); end
    join
    @(posedge clk); #1;
  endtask

  // Slave model: checks each strobe against the expected bus access.
  initial begin : slave
    bus_t b;
    int   d;
    forever begin
      @(posedge clk); #1;
      if (bus_stb) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_stb", 32'd1, 32'd0);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", 32'(bus_addr), 32'(b.addr));
          chk("bus_we", 32'(bus_we), 32'(b.we));
          if (b.we) chk("bus_wdata", 32'(bus_wdata), 32'(b.wdata));
          chk("bus_grant", 32'(grant), (b.who == 0) ? 32'd1 : 32'd2);
        end
        if (slave_mute) begin
          for (int k = 0; k < 2000 && bus_stb; k++) begin
            @(posedge clk); #1;
          end
        end else begin
          d = (slave_wait < 0) ? int'($urandom_range(0, 3)) : slave_wait;
          repeat (d) begin @(posedge clk); #1; end
          bus_ack = 1'b1;
          if (bus_we) begin
            slv_mem[int'(bus_addr)] = bus_wdata;
            bus_rdata = bus_wdata;
          end else begin
            bus_rdata = slv_mem.exists(int'(bus_addr)) ? slv_mem[int'(bus_addr)] : dflt(bus_addr);
          end
          @(posedge clk); #1;
          bus_ack   = 1'b0;
          bus_rdata = '0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every requester ack.
  initial begin : monitor
    resp_t e;
    int    who;
    forever begin
      @(negedge clk);
      if (rpi_ack || esp_ack) begin
        chk("single_ack", 32'(rpi_ack & esp_ack), 32'd0);
        if (resp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e   = resp_q.pop_front();
          who = esp_ack ? 1 : 0;
          chk("resp_owner", 32'(who), 32'(e.who));
          if (who == 0) begin
            chk("rpi_err", 32'(rpi_err), 32'(e.err));
            chk("rpi_rdata", 32'(rpi_rdata), 32'(e.rdata));
            chk("esp_idle_rdata", 32'(esp_rdata), 32'd0);
            chk("esp_idle_err", 32'(esp_err), 32'd0);
          end else begin
            chk("esp_err", 32'(esp_err), 32'(e.err));
            chk("esp_rdata", 32'(esp_rdata), 32'(e.rdata));
            chk("rpi_idle_rdata", 32'(rpi_rdata), 32'd0);
            chk("rpi_idle_err", 32'(rpi_err), 32'd0);
          end
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int    lat, lb, le, stb_cnt;
    resp_t r;
    bus_t  b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_stb", 32'(bus_stb), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rpi_ack", 32'(rpi_ack), 32'd0);
    chk("rst_esp_ack", 32'(esp_ack), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    resetn = 1'b0;
    last_served = 1;
    @(posedge clk); #1;

    // RPi write, zero-wait slave
    slave_wait = 0;
    ref_serve(0, 1'b1, 15'h4000, 16'h1234);
    access(0, 1'b1, 15'h4000, 16'h1234, lat);
    chk("t1_req_to_ack", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // RPi read with three slave wait cycles
    ref_serve(0, 1'b1, 15'h1000, 16'hAAAA);
    access(0, 1'b1, 15'h1000, 16'hAAAA, lat);
    @(posedge clk); #1;
    slave_wait = 3;
    ref_serve(0, 1'b0, 15'h1000, 16'h0000);
    access(0, 1'b0, 15'h1000, 16'h0000, lat);
    chk("t2_req_to_ack", 32'(lat), 32'd5);
    @(posedge clk); #1;

    // Reset pulse while a strobe is outstanding
    slave_mute = 1'b1;
    b.who = 0; b.we = 1'b0; b.addr = 15'h0300; b.wdata = 16'h0;
    bus_q.push_back(b);
    drive(0, 1'b1, 1'b0, 15'h0300, 16'h0);
    @(posedge clk); #1;
    chk("t6_stb_before_reset", 32'(bus_stb), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("t6_stb_after_reset", 32'(bus_stb), 32'd0);
    chk("t6_grant_after_reset", 32'(grant), 32'd0);
    chk("t6_no_ack", 32'(rpi_ack | rpi_err), 32'd0);
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 15'h0300, 16'h0);
    last_served = 1;
    repeat (3) begin @(posedge clk); #1; end
    slave_mute = 1'b0;
    slave_wait = 0;
    ref_serve(1, 1'b0, 15'h0800, 16'h0);
    access(1, 1'b0, 15'h0800, 16'h0, lat);
    chk("t6_esp_read_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Simultaneous requests alternate
    slave_wait = -1;
    repeat (4) round(1'b1, 1'b1);

    // Locked RPi burst with ESP arriving mid-burst
    slave_wait = 0;
    rpi_lock   = 1'b1;
    for (int i = 0; i < 18; i++) ref_serve(0, 1'b1, 15'h4000 + 15'(i), 16'hB000 + 16'(i));
    ref_serve(1, 1'b0, 15'h4005, 16'h0);
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          if (i > 0) begin @(posedge clk); #1; end
          access(0, 1'b1, 15'h4000 + 15'(i), 16'hB000 + 16'(i), lb);
          chk("t4_burst_latency", 32'(lb), 32'd2);
        end
        rpi_lock = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        access(1, 1'b0, 15'h4005, 16'h0, le);
      end
    join
    @(posedge clk); #1;

    // Silent slave: watchdog expiry
    slave_mute = 1'b1;
    b.who = 0; b.we = 1'b0; b.addr = 15'h0123; b.wdata = 16'h0;
    bus_q.push_back(b);
    r.who = 0; r.err = 1'b1; r.rdata = 16'h0000;
    resp_q.push_back(r);
    last_served = 0;
    stb_cnt = 0;
    fork
      access(0, 1'b0, 15'h0123, 16'h0, lat);
      begin
        for (int g = 0; g < 10 && !bus_stb; g++) begin @(posedge clk); #1; end
        while (bus_stb && stb_cnt < 1000) begin
          stb_cnt++;
          @(posedge clk); #1;
        end
      end
    join
    chk("t5_stb_cycles", 32'(stb_cnt), 32'd255);
    chk("t5_req_to_ack", 32'(lat), 32'd256);
    slave_mute = 1'b0;
    @(posedge clk); #1;

    // Randomized mix
    slave_wait = -1;
    for (int n = 0; n < 25; n++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      round(pat != 2, pat != 1);
    end

    repeat (5) begin @(posedge clk); #1; end
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
